// File: rtl/fp_add_pkg.sv
// +--------------------------------------------------------------------+
// | fp_add_pkg: widths, limits and result flags shared by FP add stages |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package fp_add_pkg;

  localparam int MANT_W_DEF = 16;
  localparam int EXP_W_DEF  = 8;

  localparam logic [EXP_W_DEF-1:0] EXP_MAX = '1;

  // Shared with the final pack stage, keep field order stable.
  typedef struct packed {
    logic zero;
    logic ovf;
    logic unf;
  } fp_flags_t;

endpackage

`default_nettype wire

// File: rtl/fp_lzc.sv
// +--------------------------------------------------------------------+
// | fp_lzc: combinational leading-zero counter, returns W for all-zero |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fp_lzc #(
  parameter int W     = 16,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     in_vec,
  output logic [CNT_W-1:0] count
);

  // Ascending scan: the highest set bit is the last to write the count.
  always_comb begin
    count = CNT_W'(W);
    for (int i = 0; i < W; i++) begin
      if (in_vec[i]) count = CNT_W'(W - 1 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_add_normalize.sv
// +--------------------------------------------------------------------+
// | fp_add_normalize: two-stage post-add normalization with valid/ready |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fp_add_normalize
  import fp_add_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W  = EXP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_sum,
  input  logic              in_cout,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_sign,
  output logic              out_zero,
  output logic              out_ovf,
  output logic              out_unf
);

  localparam int LZ_W = $clog2(MANT_W + 1);
  localparam logic [EXP_W:0] EXP_ALL = {1'b0, {EXP_W{1'b1}}};

  logic              s2_load;
  logic [LZ_W-1:0]   in_lz;

  logic              s1_valid_d, s1_valid_q;
  logic [MANT_W-1:0] s1_sum_d,   s1_sum_q;
  logic              s1_cout_d,  s1_cout_q;
  logic [EXP_W-1:0]  s1_exp_d,   s1_exp_q;
  logic              s1_sign_d,  s1_sign_q;
  logic [LZ_W-1:0]   s1_lz_d,    s1_lz_q;

  logic              out_valid_d, out_valid_q;
  logic [MANT_W-1:0] out_mant_d,  out_mant_q;
  logic [EXP_W-1:0]  out_exp_d,   out_exp_q;
  logic              out_sign_d,  out_sign_q;
  fp_flags_t         flags_d,     flags_q;

  logic [EXP_W:0]    exp_inc;
  logic [EXP_W:0]    exp_sub;

  fp_lzc #(.W(MANT_W), .CNT_W(LZ_W)) u_lzc (
    .in_vec (in_sum),
    .count  (in_lz)
  );

  assign s2_load  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_cout_d  = s1_cout_q;
    s1_exp_d   = s1_exp_q;
    s1_sign_d  = s1_sign_q;
    s1_lz_d    = s1_lz_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sum_d  = in_sum;
        s1_cout_d = in_cout;
        s1_exp_d  = in_exp;
        s1_sign_d = in_sign;
        s1_lz_d   = in_lz;
      end
    end
  end

  // One extra exponent bit so neither the increment nor the subtract wraps.
  assign exp_inc = {1'b0, s1_exp_q} + {{EXP_W{1'b0}}, 1'b1};
  assign exp_sub = {1'b0, s1_exp_q} - {{(EXP_W + 1 - LZ_W){1'b0}}, s1_lz_q};

  always_comb begin
    out_valid_d = out_valid_q;
    out_mant_d  = out_mant_q;
    out_exp_d   = out_exp_q;
    out_sign_d  = out_sign_q;
    flags_d     = flags_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_sign_d = s1_sign_q;
        flags_d    = '0;
        if (s1_cout_q) begin
          if (exp_inc >= EXP_ALL) begin
            flags_d.ovf = 1'b1;
            out_exp_d   = '1;
            out_mant_d  = '0;
          end else begin
            out_exp_d  = exp_inc[EXP_W-1:0];
            out_mant_d = {1'b1, s1_sum_q[MANT_W-1:1]};
          end
        end else if (s1_sum_q == '0) begin
          flags_d.zero = 1'b1;
          out_exp_d    = '0;
          out_mant_d   = '0;
        end else if (exp_sub[EXP_W] || (exp_sub == '0)) begin
          // exp <= lz: the result cannot be represented, flush to zero.
          flags_d.unf  = 1'b1;
          flags_d.zero = 1'b1;
          out_exp_d    = '0;
          out_mant_d   = '0;
        end else begin
          out_exp_d  = exp_sub[EXP_W-1:0];
          out_mant_d = s1_sum_q << s1_lz_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_cout_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_sign_q   <= 1'b0;
      s1_lz_q     <= '0;
      out_valid_q <= 1'b0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
      out_sign_q  <= 1'b0;
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      s1_cout_q   <= s1_cout_d;
      s1_exp_q    <= s1_exp_d;
      s1_sign_q   <= s1_sign_d;
      s1_lz_q     <= s1_lz_d;
      out_valid_q <= out_valid_d;
      out_mant_q  <= out_mant_d;
      out_exp_q   <= out_exp_d;
      out_sign_q  <= out_sign_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_mant  = out_mant_q;
  assign out_exp   = out_exp_q;
  assign out_sign  = out_sign_q;
  assign out_zero  = flags_q.zero;
  assign out_ovf   = flags_q.ovf;
  assign out_unf   = flags_q.unf;

  // The package limit must agree with the local one at default widths.
  if (EXP_W == EXP_W_DEF) begin : g_exp_max_chk
    if (EXP_ALL[EXP_W-1:0] != EXP_MAX) begin : g_exp_max_bad
      $error("EXP_MAX mismatch");
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_add_normalize.sv
// +--------------------------------------------------------------------+
// | tb_fp_add_normalize: directed vectors for the normalization stage  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_fp_add_normalize;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_sum;
  logic        in_cout;
  logic [7:0]  in_exp;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_sign;
  logic        out_zero;
  logic        out_ovf;
  logic        out_unf;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fp_add_normalize #(.MANT_W(16), .EXP_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .in_exp    (in_exp),
    .in_sign   (in_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_sign  (out_sign),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    else
      n_pass++;
  endtask

  // flags argument is {zero, ovf, unf}
  task automatic run_vec(input string tag, input logic [15:0] sum, input logic cout,
                         input logic [7:0] e, input logic s, input logic [15:0] x_mant,
                         input logic [7:0] x_exp, input logic [2:0] x_flags);
    @(negedge clk);
    in_sum = sum; in_cout = cout; in_exp = e; in_sign = s; in_valid = 1'b1;
    #1 check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_mant"},  32'(out_mant), 32'(x_mant));
    check({tag, "_exp"},   32'(out_exp), 32'(x_exp));
    check({tag, "_sign"},  32'(out_sign), 32'(s));
    check({tag, "_flags"}, 32'({out_zero, out_ovf, out_unf}), 32'(x_flags));
  endtask

  logic [15:0] bp_sum  [4];
  logic        bp_cout [4];
  logic [7:0]  bp_exp  [4];
  logic [15:0] bp_mant [4];
  logic [7:0]  bp_xexp [4];

  initial begin
    int tx, rx, first_cyc, last_cyc;
    logic acc, stale;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_sum = '0; in_cout = 1'b0; in_exp = '0; in_sign = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready), 32'd1);
    check("rst_mant",      32'(out_mant), 32'd0);
    check("rst_exp",       32'(out_exp), 32'd0);
    check("rst_sign_flags", 32'({out_sign, out_zero, out_ovf, out_unf}), 32'd0);

    run_vec("norm4",   16'h0800, 1'b0, 8'd20,  1'b1, 16'h8000, 8'd16,  3'b000);
    run_vec("carry",   16'h4001, 1'b1, 8'd10,  1'b0, 16'hA000, 8'd11,  3'b000);
    run_vec("ovf",     16'h1234, 1'b1, 8'd254, 1'b0, 16'h0000, 8'hFF,  3'b010);
    run_vec("zero",    16'h0000, 1'b0, 8'd50,  1'b1, 16'h0000, 8'd0,   3'b100);
    run_vec("unf",     16'h0001, 1'b0, 8'd10,  1'b0, 16'h0000, 8'd0,   3'b101);
    run_vec("unf_eq",  16'h8000, 1'b0, 8'd0,   1'b1, 16'h0000, 8'd0,   3'b101);
    run_vec("norm0",   16'h8000, 1'b0, 8'd1,   1'b0, 16'h8000, 8'd1,   3'b000);
    run_vec("carry_hi", 16'hFFFF, 1'b1, 8'd253, 1'b1, 16'hFFFF, 8'd254, 3'b000);
    run_vec("norm14",  16'h0003, 1'b0, 8'd15,  1'b0, 16'hC000, 8'd1,   3'b000);

    bp_sum[0] = 16'h0800; bp_cout[0] = 1'b0; bp_exp[0] = 8'd20; bp_mant[0] = 16'h8000; bp_xexp[0] = 8'd16;
    bp_sum[1] = 16'h4001; bp_cout[1] = 1'b1; bp_exp[1] = 8'd10; bp_mant[1] = 16'hA000; bp_xexp[1] = 8'd11;
    bp_sum[2] = 16'h0100; bp_cout[2] = 1'b0; bp_exp[2] = 8'd30; bp_mant[2] = 16'h8000; bp_xexp[2] = 8'd23;
    bp_sum[3] = 16'h3000; bp_cout[3] = 1'b0; bp_exp[3] = 8'd40; bp_mant[3] = 16'hC000; bp_xexp[3] = 8'd38;

    tx = 0; rx = 0; first_cyc = -1; last_cyc = -1;
    for (int cyc = 0; cyc < 40 && rx < 4; cyc++) begin
      @(negedge clk);
      if (cyc == 4) check("bp_hold_mant", 32'(out_mant), 32'h8000);
      if (cyc == 5) begin
        check("bp_accepts",  32'(tx), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = (cyc >= 5);
      in_valid  = (tx < 4);
      if (tx < 4) begin
        in_sum = bp_sum[tx]; in_cout = bp_cout[tx]; in_exp = bp_exp[tx]; in_sign = tx[0];
      end
      #1;
      if (out_valid && out_ready) begin
        check("bp_mant", 32'(out_mant), 32'(bp_mant[rx]));
        check("bp_exp",  32'(out_exp), 32'(bp_xexp[rx]));
        check("bp_sign", 32'(out_sign), 32'(rx[0]));
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        rx++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) tx++;
    end
    #1 in_valid = 1'b0;
    check("bp_all_out",  32'(rx), 32'd4);
    check("bp_back2back", 32'(last_cyc - first_cyc), 32'd3);

    // Two items in flight, then an asynchronous reset between edges.
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_sum = bp_sum[k]; in_cout = bp_cout[k]; in_exp = bp_exp[k]; in_sign = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("rstmid_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_out_valid", 32'(out_valid), 32'd0);
    check("rstmid_in_ready",  32'(in_ready), 32'd1);
    check("rstmid_mant",      32'(out_mant), 32'd0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("rstmid_no_stale", 32'(stale), 32'd0);
    check("rstmid_in_ready_after", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
